ycbcr_skin_bbox: RTL and testbench
==================================

# ycbcr_skin_bbox

Downstream stage of the RGB→YCbCr converter. Consumes its YCbCr pixel stream and timing signals, classifies each active pixel as skin/non-skin by Cb/Cr window thresholds, and emits a binary mask video stream with the same timing. It tracks the bounding box of all skin pixels per frame and publishes it at every frame boundary for the marker/tracking logic further down the chain.

## Interface
- CB_MIN, 77: inclusive lower Cb threshold.
- CB_MAX, 127: inclusive upper Cb threshold.
- CR_MIN, 133: inclusive lower Cr threshold.
- CR_MAX, 173: inclusive upper Cr threshold.
- CW, 11: coordinate width in bits; counters saturate at 2^CW−1.
- clk  in  1  pixel clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- de_in, h_sync_in, v_sync_in  in  1 each  timing from the converter; active high.
- pixel_in  in  24  {Y[23:16], Cb[15:8], Cr[7:0]}, unsigned.
- de_out, h_sync_out, v_sync_out  out  1 each  timing delayed by 1 cycle.
- pixel_out  out  24  mask: 24'hFFFFFF for a skin pixel, 24'h000000 otherwise.
- x_min, x_max, y_min, y_max  out  CW each  latched bounding box of the previous frame.
- bbox_valid  out  1  previous frame had ≥1 skin pixel.
- frame_done  out  1  one-cycle pulse when the box outputs update.

## Operation
- Hit = de_in & (CB_MIN ≤ Cb ≤ CB_MAX) & (CR_MIN ≤ Cr ≤ CR_MAX). Unsigned 8-bit compares. Y is ignored.
- x counter: 0 at the first de_in-high cycle of a line. Increments each de_in-high cycle. Cleared on the de_in falling edge. Saturates.
- y counter: increments on every de_in falling edge. Cleared on the v_sync_in rising edge. Saturates.
- Working box registers: wx_min/wy_min initialise to all-ones and wx_max/wy_max to 0. The any-hit flag initialises to 0.
- On a hit: min = min(reg, coord), max = max(reg, coord), any-hit = 1.
- Frame boundary is the v_sync_in rising edge, detected against a registered copy of v_sync_in. On that cycle:
  - Working registers are copied to the outputs.
  - bbox_valid = any-hit.
  - frame_done = 1.
  - Working registers and the y counter reinitialise.
- Same-cycle hit and frame boundary: the hit is included in the published box. Working registers still reinitialise.
- When bbox_valid = 0, the published box values are don't-care, but must equal the reinit values (min all-ones, max 0).
- Reset mid-frame discards the partial frame. The first boundary after reset publishes only pixels seen since reset.
- Reset values:
  - All outputs 0, including pixel_out, the timing outputs and frame_done.
  - x_min and y_min outputs are 0 (not all-ones).
  - Internal counters 0; working registers at their reinit values; v_sync history 0.

## Timing
- pixel_out, de_out, h_sync_out and v_sync_out lag their inputs by exactly 1 cycle, with no bubbles.
- The box outputs and bbox_valid change only in the cycle after the v_sync_in rising edge is sampled, coincident with frame_done = 1. They are stable otherwise.
- frame_done is high for exactly one cycle per v_sync_in rising edge. No pulse while rst = 1.
- Hit classification and the compare/update path fit in one register stage. No multi-cycle paths.

## Configuration
- BBOX_OVERLAY_EN defined:
  - Any pixel with de_in = 1 lying on the border of the currently published box is output as 24'hFF0000, overriding the mask value.
  - Border means x == x_min or x == x_max with y_min ≤ y ≤ y_max, or y == y_min or y == y_max with x_min ≤ x ≤ x_max.
  - The overlay is drawn only when bbox_valid = 1.
  - Latency is unchanged.
- BBOX_OVERLAY_EN undefined: pixel_out is the pure mask. The overlay comparators are not built.

## Test plan
- Reset check: hold rst for 3 cycles with random inputs → all outputs 0, frame_done never asserted.
- Threshold edges: pixels with Cb/Cr = 77/133, 127/173, 76/150 and 100/174 → mask FFFFFF, FFFFFF, 000000, 000000, each 1 cycle after input; de/hs/vs delayed by 1.
- Bounding box: 64×48 frame with skin pixels only at (10,5), (40,5) and (25,30), then a v_sync rise → x_min=10, x_max=40, y_min=5, y_max=30, bbox_valid=1, one frame_done pulse.
- Empty frame: a frame with no skin pixels followed by a v_sync rise → bbox_valid=0, x_min=y_min=all-ones, x_max=y_max=0.
- Mid-frame reset: pixels at (2,2) before rst, then (50,40) after rst, then a v_sync rise → box (50,50,40,40).
- Overlay (BBOX_OVERLAY_EN defined): second frame after a box of (10,40,5,30) → pixel (10,20) output FF0000; pixel (11,20) shows its mask value.

Source files
------------

// File: rtl/ycbcr_skin_bbox.sv
// ycbcr_skin_bbox
//   Classifies each active YCbCr pixel as skin / non-skin using inclusive
//   Cb/Cr window thresholds. Emits a binary mask stream that lags the input
//   timing by one cycle. Tracks the bounding box of skin pixels in each frame
//   and publishes it at every v_sync_in rising edge.
//
//   Optional feature macro: BBOX_OVERLAY_EN. When it is defined, active pixels
//   that lie on the border of the currently published box are painted red
//   (24'hFF0000) in place of the mask value.
//
// Ports
//   clk, rst                        pixel clock, synchronous active-high reset
//   de_in, h_sync_in, v_sync_in     input timing (active high)
//   pixel_in[23:0]                  {Y, Cb, Cr}; Y is ignored
//   de_out, h_sync_out, v_sync_out  timing delayed by one cycle
//   pixel_out[23:0]                 FFFFFF = skin, 000000 = non-skin
//   x_min, x_max, y_min, y_max      box of the previous frame
//   bbox_valid                      previous frame contained >= 1 skin pixel
//   frame_done                      one-cycle pulse when the box outputs update
module ycbcr_skin_bbox #(
    parameter logic [7:0] CB_MIN = 8'd77,
    parameter logic [7:0] CB_MAX = 8'd127,
    parameter logic [7:0] CR_MIN = 8'd133,
    parameter logic [7:0] CR_MAX = 8'd173,
    parameter int         CW     = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          de_in,
    input  logic          h_sync_in,
    input  logic          v_sync_in,
    input  logic [23:0]   pixel_in,
    output logic          de_out,
    output logic          h_sync_out,
    output logic          v_sync_out,
    output logic [23:0]   pixel_out,
    output logic [CW-1:0] x_min,
    output logic [CW-1:0] x_max,
    output logic [CW-1:0] y_min,
    output logic [CW-1:0] y_max,
    output logic          bbox_valid,
    output logic          frame_done
);

    localparam logic [CW-1:0] CMAX = '1;

    logic [7:0]    cb, cr;
    logic [7:0]    unused_y;
    logic          hit, de_fall, vs_rise;
    logic [CW-1:0] x_cnt, y_cnt;
    logic [CW-1:0] wx_min, wx_max, wy_min, wy_max;
    logic          any_hit;
    logic [CW-1:0] nx_min, nx_max, ny_min, ny_max;
    logic          n_any;
    logic [23:0]   pix_next;

    assign unused_y = pixel_in[23:16];
    assign cb       = pixel_in[15:8];
    assign cr       = pixel_in[7:0];

    assign hit = de_in && (cb >= CB_MIN) && (cb <= CB_MAX)
                       && (cr >= CR_MIN) && (cr <= CR_MAX);

    // The delayed timing outputs double as the edge-detection history:
    // they hold exactly the previous cycle's de_in / v_sync_in and reset to 0.
    assign de_fall = de_out && !de_in;
    assign vs_rise = v_sync_in && !v_sync_out;

    // Working box merged with this cycle's hit. Used both for the running
    // update and for publishing, so a hit on the boundary cycle is included.
    always_comb begin
        nx_min = wx_min;
        nx_max = wx_max;
        ny_min = wy_min;
        ny_max = wy_max;
        n_any  = any_hit;
        if (hit) begin
            if (x_cnt < wx_min) nx_min = x_cnt;
            if (x_cnt > wx_max) nx_max = x_cnt;
            if (y_cnt < wy_min) ny_min = y_cnt;
            if (y_cnt > wy_max) ny_max = y_cnt;
            n_any = 1'b1;
        end
    end

`ifdef BBOX_OVERLAY_EN
    logic on_vert, on_horz;

    // Border test against the box currently on the outputs (previous frame).
    assign on_vert = ((x_cnt == x_min) || (x_cnt == x_max))
                     && (y_cnt >= y_min) && (y_cnt <= y_max);
    assign on_horz = ((y_cnt == y_min) || (y_cnt == y_max))
                     && (x_cnt >= x_min) && (x_cnt <= x_max);

    always_comb begin
        pix_next = hit ? 24'hFFFFFF : 24'h000000;
        if (de_in && bbox_valid && (on_vert || on_horz))
            pix_next = 24'hFF0000;
    end
`else
    assign pix_next = hit ? 24'hFFFFFF : 24'h000000;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            de_out     <= 1'b0;
            h_sync_out <= 1'b0;
            v_sync_out <= 1'b0;
            pixel_out  <= 24'h000000;
            x_cnt      <= '0;
            y_cnt      <= '0;
            wx_min     <= CMAX;
            wy_min     <= CMAX;
            wx_max     <= '0;
            wy_max     <= '0;
            any_hit    <= 1'b0;
            x_min      <= '0;
            x_max      <= '0;
            y_min      <= '0;
            y_max      <= '0;
            bbox_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            de_out     <= de_in;
            h_sync_out <= h_sync_in;
            v_sync_out <= v_sync_in;
            pixel_out  <= pix_next;
            frame_done <= vs_rise;

            // x holds the coordinate of the current active pixel.
            if (de_in) begin
                if (x_cnt != CMAX) x_cnt <= x_cnt + 1'b1;
            end else if (de_fall) begin
                x_cnt <= '0;
            end

            // Frame start wins over a coincident line end.
            if (vs_rise)
                y_cnt <= '0;
            else if (de_fall && (y_cnt != CMAX))
                y_cnt <= y_cnt + 1'b1;

            if (vs_rise) begin
                x_min      <= nx_min;
                x_max      <= nx_max;
                y_min      <= ny_min;
                y_max      <= ny_max;
                bbox_valid <= n_any;
                wx_min     <= CMAX;
                wy_min     <= CMAX;
                wx_max     <= '0;
                wy_max     <= '0;
                any_hit    <= 1'b0;
            end else begin
                wx_min  <= nx_min;
                wx_max  <= nx_max;
                wy_min  <= ny_min;
                wy_max  <= ny_max;
                any_hit <= n_any;
            end
        end
    end

endmodule

// File: tb/tb_ycbcr_skin_bbox.sv
module tb_ycbcr_skin_bbox;

    logic        clk = 1'b0;
    logic        rst, de_in, h_sync_in, v_sync_in;
    logic [23:0] pixel_in;
    logic        de_out, h_sync_out, v_sync_out;
    logic [23:0] pixel_out;
    logic [10:0] x_min, x_max, y_min, y_max;
    logic        bbox_valid, frame_done;

    int checks = 0;
    int errors = 0;

    ycbcr_skin_bbox dut (
        .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in),
        .v_sync_in(v_sync_in), .pixel_in(pixel_in), .de_out(de_out),
        .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .pixel_out(pixel_out),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .bbox_valid(bbox_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    logic [23:0] e_pix;
    bit          e_de, e_hs, e_vs, e_fd;
    int          p_xmin, p_xmax, p_ymin, p_ymax;
    bit          p_valid;
    int          w_xmin, w_xmax, w_ymin, w_ymax;
    bit          w_any, m_vsp;
    int          hx[$], hy[$];

    typedef struct {
        bit de, hs, vs;
        logic [23:0] p;
        int x, y;
    } stim_t;

    function automatic bit is_skin(input logic [23:0] p);
        int cb, cr;
        cb = int'(p[15:8]);
        cr = int'(p[7:0]);
        return cb >= 77 && cb <= 127 && cr >= 133 && cr <= 173;
    endfunction

    function automatic logic [23:0] skin_px();
        logic [23:0] p;
        p[23:16] = 8'($urandom);
        p[15:8]  = 8'($urandom_range(77, 127));
        p[7:0]   = 8'($urandom_range(133, 173));
        return p;
    endfunction

    function automatic logic [23:0] nonskin_px();
        logic [23:0] p;
        p = 24'($urandom);
        if ($urandom_range(0, 1) == 0) p[15:8] = 8'($urandom_range(0, 76));
        else                          p[15:8] = 8'($urandom_range(128, 255));
        return p;
    endfunction

    function automatic bit in_hits(input int x, input int y);
        foreach (hx[i]) if (hx[i] == x && hy[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one clock cycle and compute what the block must show afterwards.
    task automatic cycle(input bit r, input bit de, input bit hs, input bit vs,
                         input logic [23:0] p, input int x, input int y);
        bit hit, rise;
`ifdef BBOX_OVERLAY_EN
        bit brd;
`endif
        rst = r; de_in = de; h_sync_in = hs; v_sync_in = vs; pixel_in = p;
        @(posedge clk); #1;
        if (r) begin
            e_pix = 24'h0; e_de = 0; e_hs = 0; e_vs = 0; e_fd = 0;
            p_xmin = 0; p_xmax = 0; p_ymin = 0; p_ymax = 0; p_valid = 0;
            w_xmin = 2047; w_ymin = 2047; w_xmax = 0; w_ymax = 0; w_any = 0;
            m_vsp = 0;
        end else begin
            hit   = de && is_skin(p);
            e_pix = hit ? 24'hFFFFFF : 24'h000000;
`ifdef BBOX_OVERLAY_EN
            brd = ((x == p_xmin || x == p_xmax) && y >= p_ymin && y <= p_ymax) ||
                  ((y == p_ymin || y == p_ymax) && x >= p_xmin && x <= p_xmax);
            if (de && p_valid && brd) e_pix = 24'hFF0000;
`endif
            e_de = de; e_hs = hs; e_vs = vs;
            rise = vs && !m_vsp;
            m_vsp = vs;
            e_fd = rise;
            if (hit) begin
                if (x < w_xmin) w_xmin = x;
                if (x > w_xmax) w_xmax = x;
                if (y < w_ymin) w_ymin = y;
                if (y > w_ymax) w_ymax = y;
                w_any = 1;
            end
            if (rise) begin
                p_xmin = w_xmin; p_xmax = w_xmax; p_ymin = w_ymin; p_ymax = w_ymax;
                p_valid = w_any;
                w_xmin = 2047; w_ymin = 2047; w_xmax = 0; w_ymax = 0; w_any = 0;
            end
        end
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 24'h0, -1, -1);
        cycle(1, 0, 0, 0, 24'h0, -1, -1);
        hx.delete(); hy.delete();
    endtask

    // One line: 3 blanking cycles then w active pixels; skin only at listed hits.
    task automatic send_line(input int y, input int w);
        for (int b = 0; b < 3; b++) cycle(0, 0, b == 0, 0, nonskin_px(), -1, -1);
        for (int x = 0; x < w; x++)
            cycle(0, 1, 0, 0, in_hits(x, y) ? skin_px() : nonskin_px(), x, y);
    endtask

    // Vertical sync: returns the number of frame_done pulses observed.
    task automatic vsync_pulse(output int fd);
        fd = 0;
        cycle(0, 0, 0, 0, 24'h0, -1, -1); fd += int'(frame_done);
        cycle(0, 0, 0, 1, 24'h0, -1, -1); fd += int'(frame_done);
        cycle(0, 0, 0, 1, 24'h0, -1, -1); fd += int'(frame_done);
        cycle(0, 0, 0, 0, 24'h0, -1, -1); fd += int'(frame_done);
        cycle(0, 0, 0, 0, 24'h0, -1, -1); fd += int'(frame_done);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom), -1, -1);
            checks++;
            if ({de_out, h_sync_out, v_sync_out, pixel_out, x_min, x_max, y_min, y_max,
                 bbox_valid, frame_done} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d: got de/hs/vs=%b%b%b pix=%h box=%0d,%0d,%0d,%0d v=%b fd=%b, want all 0",
                         i, de_out, h_sync_out, v_sync_out, pixel_out, x_min, x_max,
                         y_min, y_max, bbox_valid, frame_done);
            end
        end
        hx.delete(); hy.delete();
    endtask

    task automatic test_thresholds();
        logic [7:0]  cbv [4] = '{8'd77, 8'd127, 8'd76, 8'd100};
        logic [7:0]  crv [4] = '{8'd133, 8'd173, 8'd150, 8'd174};
        logic [23:0] want [4] = '{24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000};
        do_reset();
        cycle(0, 0, 1, 0, 24'h0, -1, -1);
        checks++;
        if ({de_out, h_sync_out, v_sync_out} !== 3'b010) begin
            errors++;
            $display("FAIL thr_hsync: got %b%b%b want 010", de_out, h_sync_out, v_sync_out);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 0, {8'($urandom), cbv[i], crv[i]}, i, 0);
            checks++;
            if (pixel_out !== want[i] || de_out !== 1'b1 || h_sync_out !== 1'b0) begin
                errors++;
                $display("FAIL thr_edge cb=%0d cr=%0d: got pix=%h de=%b hs=%b want pix=%h de=1 hs=0",
                         cbv[i], crv[i], pixel_out, de_out, h_sync_out, want[i]);
            end
        end
        cycle(0, 0, 0, 0, 24'h0, -1, -1);
        checks++;
        if (de_out !== 1'b0 || pixel_out !== 24'h0) begin
            errors++;
            $display("FAIL thr_tail: got de=%b pix=%h want 0/000000", de_out, pixel_out);
        end
    endtask

    task automatic test_bbox();
        int fd;
        do_reset();
        hx = '{10, 40, 25}; hy = '{5, 5, 30};
        for (int y = 0; y < 48; y++) send_line(y, 64);
        vsync_pulse(fd);
        checks++;
        if (fd != 1) begin
            errors++; $display("FAIL bbox_fd_count: got %0d want 1", fd);
        end
        checks++;
        if (x_min !== 11'd10 || x_max !== 11'd40 || y_min !== 11'd5 || y_max !== 11'd30 ||
            bbox_valid !== 1'b1) begin
            errors++;
            $display("FAIL bbox_box: got %0d,%0d,%0d,%0d v=%b want 10,40,5,30 v=1",
                     x_min, x_max, y_min, y_max, bbox_valid);
        end
        hx.delete(); hy.delete();
    endtask

`ifdef BBOX_OVERLAY_EN
    task automatic test_overlay();
        logic [23:0] p;
        int fd;
        hx = '{11}; hy = '{20};
        for (int y = 0; y <= 20; y++) begin
            for (int b = 0; b < 3; b++) cycle(0, 0, b == 0, 0, nonskin_px(), -1, -1);
            for (int x = 0; x < 64; x++) begin
                p = in_hits(x, y) ? skin_px() : nonskin_px();
                cycle(0, 1, 0, 0, p, x, y);
                checks++;
                if (pixel_out !== e_pix) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL ovl_pix (%0d,%0d): got %h want %h", x, y, pixel_out, e_pix);
                end
                if (y == 20 && (x == 10 || x == 11)) begin
                    checks++;
                    if (pixel_out !== (x == 10 ? 24'hFF0000 : 24'hFFFFFF)) begin
                        errors++;
                        $display("FAIL ovl_point (%0d,20): got %h want %h", x, pixel_out,
                                 x == 10 ? 24'hFF0000 : 24'hFFFFFF);
                    end
                end
            end
        end
        vsync_pulse(fd);
        hx.delete(); hy.delete();
    endtask
`endif

    task automatic test_empty();
        int fd;
        do_reset();
        for (int y = 0; y < 6; y++) send_line(y, 10);
        vsync_pulse(fd);
        checks++;
        if (fd != 1 || bbox_valid !== 1'b0 || x_min !== 11'h7FF || y_min !== 11'h7FF ||
            x_max !== 11'd0 || y_max !== 11'd0) begin
            errors++;
            $display("FAIL empty_frame: got fd=%0d v=%b box=%h,%h,%h,%h want 1 0 7ff,0,7ff,0",
                     fd, bbox_valid, x_min, x_max, y_min, y_max);
        end
    endtask

    task automatic test_midreset();
        int fd;
        do_reset();
        hx = '{2}; hy = '{2};
        send_line(0, 64); send_line(1, 64); send_line(2, 6);
        do_reset();
        hx = '{50}; hy = '{40};
        for (int y = 0; y <= 40; y++) send_line(y, 64);
        vsync_pulse(fd);
        checks++;
        if (fd != 1 || bbox_valid !== 1'b1 || x_min !== 11'd50 || x_max !== 11'd50 ||
            y_min !== 11'd40 || y_max !== 11'd40) begin
            errors++;
            $display("FAIL midreset_box: got fd=%0d v=%b box=%0d,%0d,%0d,%0d want 1 1 50,50,40,40",
                     fd, bbox_valid, x_min, x_max, y_min, y_max);
        end
        hx.delete(); hy.delete();
    endtask

    task automatic test_random();
        stim_t q[$];
        stim_t s;
        int w, h;
        do_reset();
        for (int f = 0; f < 5; f++) begin
            w = $urandom_range(4, 24);
            h = $urandom_range(2, 10);
            for (int y = 0; y < h; y++) begin
                for (int b = 0; b < 3; b++)
                    q.push_back('{0, b == 0, 0, 24'($urandom), -1, -1});
                for (int x = 0; x < w; x++)
                    q.push_back('{1, 0, 0,
                                  ($urandom_range(0, 9) < 3) ? skin_px() : 24'($urandom), x, y});
            end
            q.push_back('{0, 0, 0, 24'h0, -1, -1});
            q.push_back('{0, 0, 1, 24'h0, -1, -1});
            q.push_back('{0, 0, 0, 24'h0, -1, -1});
        end
        foreach (q[i]) begin
            s = q[i];
            cycle(0, s.de, s.hs, s.vs, s.p, s.x, s.y);
            checks++;
            if (pixel_out !== e_pix || {de_out, h_sync_out, v_sync_out} !== {e_de, e_hs, e_vs}) begin
                errors++;
                if (errors < 20)
                    $display("FAIL rnd_stream cyc %0d: got pix=%h t=%b%b%b want pix=%h t=%b%b%b",
                             i, pixel_out, de_out, h_sync_out, v_sync_out, e_pix, e_de, e_hs, e_vs);
            end
            checks++;
            if (frame_done !== e_fd || bbox_valid !== p_valid ||
                x_min !== 11'(p_xmin) || x_max !== 11'(p_xmax) ||
                y_min !== 11'(p_ymin) || y_max !== 11'(p_ymax)) begin
                errors++;
                if (errors < 20)
                    $display("FAIL rnd_box cyc %0d: got fd=%b v=%b %0d,%0d,%0d,%0d want fd=%b v=%b %0d,%0d,%0d,%0d",
                             i, frame_done, bbox_valid, x_min, x_max, y_min, y_max,
                             e_fd, p_valid, p_xmin, p_xmax, p_ymin, p_ymax);
            end
        end
    endtask

    // Hit on the same cycle as the frame boundary, then an immediate second boundary.
    task automatic test_back_to_back();
        do_reset();
        cycle(0, 1, 0, 1, skin_px(), 0, 0);
        checks++;
        if (frame_done !== 1'b1 || bbox_valid !== 1'b1 || {x_min, x_max, y_min, y_max} !== '0) begin
            errors++;
            $display("FAIL b2b_same_cycle: got fd=%b v=%b box=%0d,%0d,%0d,%0d want 1 1 0,0,0,0",
                     frame_done, bbox_valid, x_min, x_max, y_min, y_max);
        end
        cycle(0, 0, 0, 0, 24'h0, -1, -1);
        checks++;
        if (frame_done !== 1'b0 || bbox_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold: got fd=%b v=%b want 0 1", frame_done, bbox_valid);
        end
        cycle(0, 0, 0, 1, 24'h0, -1, -1);
        checks++;
        if (frame_done !== 1'b1 || bbox_valid !== 1'b0 || x_min !== 11'h7FF ||
            y_min !== 11'h7FF || x_max !== 11'd0 || y_max !== 11'd0) begin
            errors++;
            $display("FAIL b2b_second: got fd=%b v=%b box=%h,%h,%h,%h want 1 0 7ff,0,7ff,0",
                     frame_done, bbox_valid, x_min, x_max, y_min, y_max);
        end
        cycle(0, 0, 0, 1, 24'h0, -1, -1);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_held_vsync: got fd=%b want 0", frame_done);
        end
    endtask

    initial begin
        rst = 1'b1; de_in = 0; h_sync_in = 0; v_sync_in = 0; pixel_in = 24'h0;
        test_reset();
        test_thresholds();
        test_bbox();
`ifdef BBOX_OVERLAY_EN
        test_overlay();
`endif
        test_empty();
        test_midreset();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
